// File: rtl/dispatch_pkg.sv
// Shared opcode constants, class/state enums and the J/JAL target helper.
package dispatch_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [2:0] OP_IMM_HI = 3'b001;
    localparam logic [5:0] FN_JR     = 6'b001000;

    localparam int unsigned JW = 32;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JR      = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } inst_class_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_BR  = 2'd1,
        REDIRECT = 2'd2
    } disp_state_e;

    // Pseudo-direct target: high nibble of PC+4 (wrapping), 26-bit index, word aligned.
    function automatic logic [JW-1:0] jump_target(input logic [JW-1:0] pc,
                                                  input logic [JW-1:0] inst);
        return ((pc + JW'(4)) & 32'hF000_0000) | ((inst << 2) & 32'h0FFF_FFFC);
    endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Dispatch-stage bus: IFQ head/pop, redirect, branch resolution and issue handshake.
interface dispatch_unit_if
    import dispatch_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 32
);
    logic [IW-1:0] inst;
    logic [AW-1:0] pc_in;
    logic          empty;
    logic          inst_rd_en;
    logic [AW-1:0] jmp_branch_address;
    logic          jmp_branch_valid;
    logic          br_resolve_valid;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_inst;
    logic [AW-1:0] issue_pc;
    inst_class_e   issue_class;

    modport master (
        input  inst, pc_in, empty, br_resolve_valid, br_taken, br_target, issue_ready,
        output inst_rd_en, jmp_branch_address, jmp_branch_valid,
               issue_valid, issue_inst, issue_pc, issue_class
    );

    modport slave (
        output inst, pc_in, empty, br_resolve_valid, br_taken, br_target, issue_ready,
        input  inst_rd_en, jmp_branch_address, jmp_branch_valid,
               issue_valid, issue_inst, issue_pc, issue_class
    );
endinterface

// File: rtl/dispatch_unit_inst_decoder.sv
// Combinational instruction classifier; is_j_o marks a plain J (consumed, not forwarded).
module inst_decoder
    import dispatch_pkg::*;
#(
    parameter int unsigned IW = 32
) (
    input  logic [IW-1:0] inst_i,
    output inst_class_e   cls_o,
    output logic          is_j_o
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;

    assign op          = inst_i[31:26];
    assign funct       = inst_i[5:0];
    assign unused_bits = ^inst_i[25:6];

    // Opcode/funct classification; J reports as JAL so both share the redirect path.
    always_comb begin
        cls_o  = CLS_ILLEGAL;
        is_j_o = 1'b0;
        if (op[5:3] == OP_IMM_HI) begin
            cls_o = CLS_ALU;
        end else begin
            case (op)
                OP_RTYPE: cls_o = (funct == FN_JR) ? CLS_JR : CLS_ALU;
                OP_J: begin
                    cls_o  = CLS_JAL;
                    is_j_o = 1'b1;
                end
                OP_JAL:  cls_o = CLS_JAL;
                OP_BEQ:  cls_o = CLS_BRANCH;
                OP_BNE:  cls_o = CLS_BRANCH;
                OP_LW:   cls_o = CLS_LOAD;
                OP_SW:   cls_o = CLS_STORE;
                default: cls_o = CLS_ILLEGAL;
            endcase
        end
    end
endmodule

// File: rtl/dispatch_unit.sv
// In-order dispatch: pops the IFQ, resolves J/JAL locally, stalls on BEQ/BNE/JR,
// and forwards through a one-entry valid/ready output register.
module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 32
) (
    input logic            clk,
    input logic            rst,
    dispatch_unit_if.master bus
);
    disp_state_e   state_q;
    logic          issue_valid_q;
    logic [IW-1:0] issue_inst_q;
    logic [AW-1:0] issue_pc_q;
    inst_class_e   issue_class_q;
    logic [AW-1:0] jmp_addr_q;
    logic          jmp_valid_q;

    inst_class_e   dec_cls;
    logic          dec_is_j;
    logic          can_pop_c;

    inst_decoder #(.IW(IW)) u_dec (
        .inst_i (bus.inst),
        .cls_o  (dec_cls),
        .is_j_o (dec_is_j)
    );

    // Pop when running, head present and the output slot is free or draining; held low in reset.
    assign can_pop_c = rst && (state_q == RUN) && !bus.empty
                       && (!issue_valid_q || bus.issue_ready);

    assign bus.inst_rd_en         = can_pop_c;
    assign bus.jmp_branch_address = jmp_addr_q;
    assign bus.jmp_branch_valid   = jmp_valid_q;
    assign bus.issue_valid        = issue_valid_q;
    assign bus.issue_inst         = issue_inst_q;
    assign bus.issue_pc           = issue_pc_q;
    assign bus.issue_class        = issue_class_q;

    // Dispatch FSM, output register and redirect register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            issue_valid_q <= 1'b0;
            issue_inst_q  <= '0;
            issue_pc_q    <= '0;
            issue_class_q <= CLS_ALU;
            jmp_addr_q    <= '0;
            jmp_valid_q   <= 1'b0;
        end else begin
            if (can_pop_c && !dec_is_j) begin
                issue_valid_q <= 1'b1;
                issue_inst_q  <= bus.inst;
                issue_pc_q    <= bus.pc_in;
                issue_class_q <= dec_cls;
            end else if (bus.issue_ready) begin
                issue_valid_q <= 1'b0;
            end

            jmp_valid_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (can_pop_c) begin
                        if (dec_cls == CLS_JAL) begin
                            jmp_addr_q  <= AW'(jump_target(JW'(bus.pc_in), JW'(bus.inst)));
                            jmp_valid_q <= 1'b1;
                            state_q     <= REDIRECT;
                        end else if (dec_cls == CLS_BRANCH || dec_cls == CLS_JR) begin
                            state_q <= WAIT_BR;
                        end
                    end
                end
                WAIT_BR: begin
                    if (bus.br_resolve_valid) begin
                        if (bus.br_taken) begin
                            jmp_addr_q  <= bus.br_target;
                            jmp_valid_q <= 1'b1;
                            state_q     <= REDIRECT;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                REDIRECT: state_q <= RUN;
                default:  state_q <= RUN;
            endcase
        end
    end
endmodule
